// File: rtl/lfsr_checker_if.sv
// ---------------------------------------------------------------------------
// lfsr_checker_if
//
// Groups the serial pattern input and the checker status outputs of
// lfsr_checker into one bundle. clk and rst stay plain ports on the module.
//
// Signals:
//   in_valid    : in_bit carries a new sequence bit this cycle
//   in_bit      : received serial bit
//   clr_err     : synchronous clear of err_count
//   locked      : checker is in LOCKED
//   sync_state  : 0 = HUNT, 1 = VERIFY, 2 = LOCKED
//   err_pulse   : one-cycle flag for a bad bit while LOCKED
//   err_count   : saturating error count (ERR_W bits)
//
// Modports:
//   master : pattern source / test controller side
//   slave  : checker side (used by lfsr_checker)
// ---------------------------------------------------------------------------
interface lfsr_checker_if #(
    parameter int ERR_W = 16
);
    logic             in_valid;
    logic             in_bit;
    logic             clr_err;
    logic             locked;
    logic [1:0]       sync_state;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;

    modport master (
        output in_valid,
        output in_bit,
        output clr_err,
        input  locked,
        input  sync_state,
        input  err_pulse,
        input  err_count
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  clr_err,
        output locked,
        output sync_state,
        output err_pulse,
        output err_count
    );
endinterface

// File: rtl/lfsr_checker.sv
// ---------------------------------------------------------------------------
// lfsr_checker
//
// Receive-side companion of the Fibonacci LFSR pattern generator. The serial
// stream is loaded into a local LFSR (HUNT), the loaded state is qualified by
// LOCK_CNT consecutive correct predictions (VERIFY), and from then on the
// local LFSR free-runs on its own predictions (LOCKED, flywheel) so that
// corrupted received bits never disturb the reference. Each mismatch while
// LOCKED raises err_pulse and bumps a saturating error counter; too many
// errors inside one LOSS_WIN-bit window drop the checker back to HUNT.
//
// Parameters:
//   WIDTH       : LFSR length in bits (>= 3)
//   TAPS        : feedback mask, identical to the generator's
//   LOCK_CNT    : consecutive correct predictions needed for lock
//   LOSS_WIN    : loss-of-lock window length in valid bits
//   LOSS_THRESH : errors within one window that force a relock
//   ERR_W       : err_count width
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active low
//   bus  : lfsr_checker_if.slave (in_valid, in_bit, clr_err in;
//          locked, sync_state, err_pulse, err_count out)
//
// Build option:
//   LFSR_CHK_ERRCNT_EN : when defined, err_count and clr_err are built.
//                        When undefined, err_count is tied to zero and
//                        clr_err is ignored; everything else is unchanged.
// ---------------------------------------------------------------------------
module lfsr_checker #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] TAPS        = 8'hB8,
    parameter int               LOCK_CNT    = 16,
    parameter int               LOSS_WIN    = 32,
    parameter int               LOSS_THRESH = 8,
    parameter int               ERR_W       = 16
) (
    input  logic           clk,
    input  logic           rst,
    lfsr_checker_if.slave  bus
);

    // Counter widths sized to hold their terminal values.
    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(LOSS_WIN + 1);
    localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   s_reg;
    logic [FILL_W-1:0]  fill_reg;
    logic [MATCH_W-1:0] match_reg;
    logic [WIN_W-1:0]   win_cnt_reg;
    logic [WERR_W-1:0]  win_err_reg;
    logic               locked_reg;
    logic               err_pulse_reg;

    // -----------------------------------------------------------------------
    // Prediction: parity of the tapped register bits.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] tap_bits;
    logic             predict;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
            assign tap_bits[gi] = s_reg[gi] & TAPS[gi];
        end
    endgenerate

    assign predict = ^tap_bits;

    // -----------------------------------------------------------------------
    // Next-value helpers shared by the state machine.
    // -----------------------------------------------------------------------
    logic             mismatch;
    logic [WIDTH-1:0] s_load;      // register with the received bit shifted in
    logic [WIDTH-1:0] s_fly;       // register with the predicted bit shifted in
    logic             fill_done;   // this bit completes the WIDTH-bit load
    logic             match_done;  // this match is the LOCK_CNT-th in a row
    logic             win_last;    // this bit closes the current window
    logic             thresh_hit;  // this error reaches LOSS_THRESH in window

    assign mismatch   = bus.in_bit ^ predict;
    assign s_load     = {s_reg[WIDTH-2:0], bus.in_bit};
    assign s_fly      = {s_reg[WIDTH-2:0], predict};
    assign fill_done  = (fill_reg >= FILL_W'(WIDTH - 1));
    assign match_done = (match_reg == MATCH_W'(LOCK_CNT - 1));
    assign win_last   = (win_cnt_reg == WIN_W'(LOSS_WIN - 1));
    assign thresh_hit = mismatch && (win_err_reg == WERR_W'(LOSS_THRESH - 1));

    // -----------------------------------------------------------------------
    // Synchronisation state machine. All outputs come straight from
    // registers; nothing but err_pulse changes while in_valid is low.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_HUNT;
            s_reg         <= '0;
            fill_reg      <= '0;
            match_reg     <= '0;
            win_cnt_reg   <= '0;
            win_err_reg   <= '0;
            locked_reg    <= 1'b0;
            err_pulse_reg <= 1'b0;
        end else begin
            err_pulse_reg <= 1'b0;

            if (bus.in_valid) begin
                case (state_reg)
                    ST_HUNT: begin
                        s_reg <= s_load;
                        if (fill_done) begin
                            // Fill saturates at WIDTH so that, while an
                            // all-zero register keeps us here, every new
                            // bit re-evaluates the freshly shifted state.
                            fill_reg <= FILL_W'(WIDTH);
                            if (s_load != '0) begin
                                state_reg <= ST_VERIFY;
                                match_reg <= '0;
                            end
                        end else begin
                            fill_reg <= fill_reg + FILL_W'(1);
                        end
                    end

                    ST_VERIFY: begin
                        s_reg <= s_load;
                        if (mismatch) begin
                            // The register already holds WIDTH-1 recent
                            // received bits; one more bit re-qualifies.
                            state_reg <= ST_HUNT;
                            fill_reg  <= FILL_W'(WIDTH - 1);
                        end else if (match_done) begin
                            state_reg   <= ST_LOCKED;
                            locked_reg  <= 1'b1;
                            win_cnt_reg <= '0;
                            win_err_reg <= '0;
                        end else begin
                            match_reg <= match_reg + MATCH_W'(1);
                        end
                    end

                    ST_LOCKED: begin
                        // Flywheel: only the prediction feeds the register.
                        s_reg         <= s_fly;
                        err_pulse_reg <= mismatch;
                        if (thresh_hit) begin
                            state_reg   <= ST_HUNT;
                            locked_reg  <= 1'b0;
                            fill_reg    <= '0;
                            match_reg   <= '0;
                            win_cnt_reg <= '0;
                            win_err_reg <= '0;
                        end else if (win_last) begin
                            // Errors on the closing bit of a window are
                            // below threshold and expire with the window.
                            win_cnt_reg <= '0;
                            win_err_reg <= '0;
                        end else begin
                            win_cnt_reg <= win_cnt_reg + WIN_W'(1);
                            win_err_reg <= win_err_reg + WERR_W'(mismatch);
                        end
                    end

                    default: begin
                        state_reg  <= ST_HUNT;
                        locked_reg <= 1'b0;
                        fill_reg   <= '0;
                        match_reg  <= '0;
                    end
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Error counter. clr_err wins over an error in the same cycle; the
    // pulse for that error is still produced by the state machine above.
    // -----------------------------------------------------------------------
`ifdef LFSR_CHK_ERRCNT_EN
    logic [ERR_W-1:0] err_count_reg;
    logic             count_err;

    assign count_err = bus.in_valid && (state_reg == ST_LOCKED) && mismatch;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_count_reg <= '0;
        end else if (bus.clr_err) begin
            err_count_reg <= '0;
        end else if (count_err && (err_count_reg != {ERR_W{1'b1}})) begin
            err_count_reg <= err_count_reg + ERR_W'(1);
        end
    end

    assign bus.err_count = err_count_reg;
`else
    logic unused_clr_err;

    assign unused_clr_err = bus.clr_err;
    assign bus.err_count  = '0;
`endif

    assign bus.locked     = locked_reg;
    assign bus.sync_state = state_reg;
    assign bus.err_pulse  = err_pulse_reg;

endmodule

// File: tb/tb_lfsr_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_checker
//
// Directed bench for lfsr_checker (WIDTH=8, TAPS=8'hB8, LOCK_CNT=16,
// LOSS_WIN=32, LOSS_THRESH=8, ERR_W=4). A small generator model produces the
// pattern; each expected value is a hand-derived constant for that stimulus.
// Inputs are driven on the falling edge and outputs sampled on the next
// falling edge, i.e. half a cycle after the capturing rising edge.
// ---------------------------------------------------------------------------
module tb_lfsr_checker;

`ifdef LFSR_CHK_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lfsr_checker_if #(.ERR_W(4)) bus ();

    lfsr_checker #(
        .WIDTH       (8),
        .TAPS        (8'hB8),
        .LOCK_CNT    (16),
        .LOSS_WIN    (32),
        .LOSS_THRESH (8),
        .ERR_W       (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks    = 0;
    int         failures  = 0;
    logic [7:0] gen_reg;
    int         since_lock;
    int         pulses;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Expected err_count: only meaningful when the counter is built.
    function automatic logic [31:0] exp_cnt(input int v);
        return CNT_EN ? v : 0;
    endfunction

    // One clock: drive at the falling edge, sample at the next falling edge.
    task automatic tick(input logic v, input logic b, input logic c);
        bus.in_valid = v;
        bus.in_bit   = b;
        bus.clr_err  = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Send the next generator bit, optionally inverted.
    task automatic send(input logic flip);
        logic b;
        b       = ^(gen_reg & 8'hB8);
        gen_reg = {gen_reg[6:0], b};
        tick(1'b1, b ^ flip, 1'b0);
        since_lock++;
        if (bus.err_pulse === 1'b1) pulses++;
    endtask

    // 24 clean bits from HUNT with fill 0: VERIFY after bit 8, LOCKED after
    // bit 24. gap = idle cycles (with junk in_bit) before every valid bit.
    task automatic lock_seq(input string name, input int gap);
        for (int i = 1; i <= 24; i++) begin
            for (int g = 0; g < gap; g++)
                tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            if (i == 24 && gap > 0)
                check_val({name, "_locked_gap_before_24"}, bus.locked, 0);
            send(1'b0);
            if (i == 7)  check_val({name, "_state_bit7"},  bus.sync_state, 0);
            if (i == 8)  check_val({name, "_state_bit8"},  bus.sync_state, 1);
            if (i == 23) check_val({name, "_locked_bit23"}, bus.locked, 0);
            if (i == 23) check_val({name, "_state_bit23"}, bus.sync_state, 1);
            if (i == 24) check_val({name, "_locked_bit24"}, bus.locked, 1);
            if (i == 24) check_val({name, "_state_bit24"}, bus.sync_state, 2);
        end
        since_lock = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic b;

        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        bus.clr_err  = 1'b0;
        gen_reg      = 8'h01;
        since_lock   = 0;
        pulses       = 0;

        // ---- reset state ----
        @(negedge clk);
        tick(1'b0, 1'b0, 1'b0);
        check_val("rst_locked", bus.locked, 0);
        check_val("rst_state", bus.sync_state, 0);
        check_val("rst_pulse", bus.err_pulse, 0);
        check_val("rst_count", bus.err_count, 0);
        rst = 1'b1;

        // ---- clean stream, seed 01: lock at bit 24, clean to 1000 bits ----
        lock_seq("clean", 0);
        pulses = 0;
        bad    = 0;
        for (int i = 0; i < 976; i++) begin
            send(1'b0);
            if (bus.locked !== 1'b1) bad++;
        end
        check_val("clean_pulses", pulses, 0);
        check_val("clean_unlocked_cycles", bad, 0);
        check_val("clean_count", bus.err_count, 0);

        // ---- single flipped bit while locked ----
        send(1'b1);
        check_val("flip1_pulse", bus.err_pulse, 1);
        check_val("flip1_count", bus.err_count, exp_cnt(1));
        check_val("flip1_locked", bus.locked, 1);
        send(1'b0);
        check_val("flip1_pulse_after", bus.err_pulse, 0);
        pulses = 0;
        for (int i = 0; i < 100; i++) send(1'b0);
        check_val("flip1_flywheel_pulses", pulses, 0);
        check_val("flip1_count_after", bus.err_count, exp_cnt(1));

        // ---- 8 errors inside one window: loss of lock, then relock ----
        while (since_lock % 32 != 0) send(1'b0);
        for (int i = 1; i <= 8; i++) begin
            send(1'b1);
            if (i == 7) check_val("loss_locked_err7", bus.locked, 1);
        end
        check_val("loss_locked_err8", bus.locked, 0);
        check_val("loss_state_err8", bus.sync_state, 0);
        check_val("loss_pulse_err8", bus.err_pulse, 1);
        check_val("loss_count", bus.err_count, exp_cnt(9));
        lock_seq("relock", 0);

        // ---- one error per window for 20 windows: saturation at 15 ----
        for (int w = 0; w < 20; w++) begin
            send(1'b1);
            for (int i = 0; i < 31; i++) send(1'b0);
        end
        check_val("sat_count", bus.err_count, exp_cnt(15));
        check_val("sat_locked", bus.locked, 1);

        // clr_err together with an error: cleared, pulse still fires
        b       = ^(gen_reg & 8'hB8);
        gen_reg = {gen_reg[6:0], b};
        tick(1'b1, ~b, 1'b1);
        check_val("clr_count", bus.err_count, 0);
        check_val("clr_pulse", bus.err_pulse, 1);
        send(1'b0);
        check_val("clr_count_after", bus.err_count, 0);

        // ---- 40 zeros from reset stay in HUNT ----
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (bus.locked !== 1'b0 || bus.sync_state !== 2'd0) bad++;
        end
        check_val("zeros_not_hunt", bad, 0);
        // State 8'h8D emits 0000000_1 and then continues as seed 8'h01, so
        // the zero-filled register becomes valid exactly on the 8th bit.
        gen_reg = 8'h8D;
        lock_seq("after_zeros", 0);

        // ---- in_valid every 3rd cycle: lock after 24 valid bits ----
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        rst     = 1'b1;
        gen_reg = 8'h01;
        lock_seq("gapped", 2);
        send(1'b1);
        check_val("gapped_err_count", bus.err_count, exp_cnt(1));

        // ---- reset while LOCKED, with a bad bit on the same edge ----
        rst = 1'b0;
        tick(1'b1, 1'b1, 1'b0);
        check_val("midrst_locked", bus.locked, 0);
        check_val("midrst_state", bus.sync_state, 0);
        check_val("midrst_pulse", bus.err_pulse, 0);
        check_val("midrst_count", bus.err_count, 0);
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the `lfsr` pattern generator. It consumes the generator's serial `out` stream, self-synchronises a local Fibonacci LFSR to it and flywheels once locked. It flags every bit that deviates from the predicted sequence, counts errors and detects loss of lock. It sits at the far end of any link or datapath carrying the LFSR pattern, and is the pass/fail monitor for pattern-based tests.

## Interface
- `WIDTH`, 8: LFSR length in bits (≥3).
- `TAPS`, 8'hB8: feedback mask, same value as the generator (x^8+x^6+x^5+x^4+1).
- `LOCK_CNT`, 16: consecutive correct predictions required to declare lock.
- `LOSS_WIN`, 32: window length, in valid bits, for loss-of-lock evaluation.
- `LOSS_THRESH`, 8: errors within one window that force a relock.
- `ERR_W`, 16: error counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `in_valid` in 1: `in_bit` is a new sequence bit this cycle.
- `in_bit` in 1: received serial bit.
- `clr_err` in 1: synchronous clear of `err_count`.
- `locked` out 1: high while in LOCKED.
- `sync_state` out 2: 0 = HUNT, 1 = VERIFY, 2 = LOCKED.
- `err_pulse` out 1: one-cycle flag for a mismatching bit while LOCKED.
- `err_count` out ERR_W: saturating error count.

## Operation
- **Shift register and prediction**
  - `s[WIDTH-1:0]` is the local LFSR.
  - Predicted bit `p = ^(s & TAPS)`.
  - Update only on `in_valid`; no state changes while `in_valid` = 0.
- **HUNT**
  - Per valid bit: `s <= {s[WIDTH-2:0], in_bit}`, and increment the fill counter.
  - After WIDTH bits have been loaded, go to VERIFY if `s` is nonzero.
  - An all-zero `s` is illegal: stay in HUNT and keep shifting.
- **VERIFY**
  - Per valid bit: compare `in_bit` with `p`, then `s <= {s[WIDTH-2:0], in_bit}`.
  - Match: increment the match counter. When it reaches LOCK_CNT, go to LOCKED.
  - Mismatch: return to HUNT with the fill counter at WIDTH−1, so a single further bit re-qualifies.
  - No errors are counted in VERIFY.
- **LOCKED (flywheel)**
  - Per valid bit: `s <= {s[WIDTH-2:0], p}`. The received bit never corrupts `s`.
  - Mismatch: assert `err_pulse`, increment `err_count` and the window error counter.
  - The window counter counts valid bits. At LOSS_WIN it restarts and the window error counter clears.
  - Window error counter reaching LOSS_THRESH: go to HUNT and clear the fill, match and window counters. `err_count` is kept.
- **`err_count`**
  - Saturates at 2^ERR_W−1.
  - `clr_err` has priority: an error in the same cycle as `clr_err` is not counted, but `err_pulse` still fires.
- **Reset** (`rst` low at a clock edge)
  - Values: state = HUNT, `s` = 0, all counters = 0, `locked` = 0, `sync_state` = 0, `err_pulse` = 0, `err_count` = 0.
  - Reset mid-LOCKED drops lock on the same edge.

## Timing
- All outputs are registered.
- `err_pulse` is high exactly one cycle, on the cycle after the edge that sampled the bad bit.
- `locked` rises on the cycle after the edge that samples the LOCK_CNT-th consecutive match.
  - From reset with a clean stream, this is WIDTH + LOCK_CNT valid bits (24 with defaults).
- `locked` falls on the cycle after the edge that registers the LOSS_THRESH-th window error.
- The first in-window error after a HUNT exit is counted only once LOCKED is reached.
- Gaps in `in_valid` only stretch the timing; bit counts are unchanged.

## Configuration
- `LFSR_CHK_ERRCNT_EN` defined: `err_count` and the `clr_err` logic are built as specified above.
- Not defined:
  - `err_count` is tied to 0 and `clr_err` is ignored.
  - `err_pulse`, lock and loss-of-lock behaviour are unchanged.

## Test plan
- Generator with seed 8'h01 and defaults, `in_valid` = 1: `locked` rises after exactly 24 bits, `sync_state` goes 0→1→2, and `err_count` stays 0 for 1000 bits.
- After lock, flip one bit: `err_pulse` is high for one cycle, `err_count` = 1, `locked` stays high, and following bits give no errors (flywheel).
- After lock, flip 8 bits within a 32-bit window: `locked` falls on the 8th error and `sync_state` = 0. Clean bits then relock after 24 further bits, and `err_count` = 8.
- Drive 40 zero bits from reset: the block stays in HUNT and `locked` never rises. Then feed a clean stream: lock after 24 bits.
- Clean stream with `in_valid` high every 3rd cycle: lock after 24 valid bits (72 cycles). Pull `rst` low while LOCKED: on the next cycle all outputs are 0.
- With `ERR_W` = 4, inject one error per 32-bit window for 20 windows: `err_count` saturates at 15. Then `clr_err` together with an error gives `err_count` = 0 and `err_pulse` = 1. Without the macro, `err_count` stays 0 throughout.
